// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Conditions four raw board switch/button inputs for the downstream
// combinational stage y = a'bd' + bc + bd'. Each bit passes through its own
// SYNC_STAGES-deep synchronizer and then its own debounce state machine. A
// debounced output only takes a new value after the synchronized input has
// differed from it for DEBOUNCE_CYCLES consecutive clocks. Any bounce back
// to the current output value discards the partial count.
//
// Optional feature macro: DEBOUNCE_CHANGE_PULSE_EN
//   When defined, adds changeWire. It is a one-cycle pulse on the edge where
//   any debounced output updates. Updates on several bits in the same edge
//   give one pulse.
//
// Parameters:
//   DEBOUNCE_CYCLES  qualification time in clocks (>= 1)
//   SYNC_STAGES      synchronizer depth per bit (>= 2)
//
// Ports:
//   clkWire     in   system clock, rising edge
//   rstWire     in   synchronous active-high reset
//   rawWire     in   [3]=a [2]=b [1]=c [0]=d, asynchronous raw inputs
//   aWire..dWire out debounced, registered outputs
//   busyWire    out  high while any bit is qualifying a change
//   changeWire  out  update pulse (only with DEBOUNCE_CHANGE_PULSE_EN)
//
// Per-bit state table:
//   state   | meaning
//   IDLE    | synchronized input equals the debounced value, counter at 0
//   PENDING | synchronized input differs, counter running toward terminal
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clkWire,
    input  logic       rstWire,
    input  logic [3:0] rawWire,
    output logic       aWire,
    output logic       bWire,
    output logic       cWire,
    output logic       dWire,
    output logic       busyWire
`ifdef DEBOUNCE_CHANGE_PULSE_EN
    ,
    output logic       changeWire
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter value seen on the edge that commits the new value.
    localparam logic [CW-1:0] TERM_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_chain [4];
    state_t                 state      [4];
    logic [CW-1:0]          count      [4];
    logic [3:0]             stable;

    logic [3:0] sync_bit;
    logic [3:0] differs;
    logic [3:0] update;
    logic [3:0] pend_next;

    // update:    the bit commits its new value on this edge.
    // pend_next: the bit is in PENDING after this edge. busyWire registers
    //            the OR of this, so it drops on the same edge as the commit.
    always_comb begin
        sync_bit  = '0;
        differs   = '0;
        update    = '0;
        pend_next = '0;
        for (int i = 0; i < 4; i++) begin
            sync_bit[i] = sync_chain[i][SYNC_STAGES-1];
            differs[i]  = sync_bit[i] ^ stable[i];
            if (state[i] == IDLE) begin
                // With a one-cycle qualification time, IDLE commits directly.
                update[i] = differs[i] && (DEBOUNCE_CYCLES == 1);
            end else begin
                update[i] = differs[i] && (count[i] == TERM_COUNT);
            end
            pend_next[i] = differs[i] && !update[i];
        end
    end

    always_ff @(posedge clkWire) begin
        if (rstWire) begin
            for (int i = 0; i < 4; i++) begin
                sync_chain[i] <= '0;
                state[i]      <= IDLE;
                count[i]      <= '0;
            end
            stable   <= '0;
            busyWire <= 1'b0;
`ifdef DEBOUNCE_CHANGE_PULSE_EN
            changeWire <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (SYNC_STAGES > 1) begin
                    sync_chain[i] <= {sync_chain[i][SYNC_STAGES-2:0], rawWire[i]};
                end else begin
                    sync_chain[i] <= {SYNC_STAGES{rawWire[i]}};
                end

                case (state[i])
                    IDLE: begin
                        if (update[i]) begin
                            stable[i] <= sync_bit[i];
                            count[i]  <= '0;
                        end else if (differs[i]) begin
                            state[i] <= PENDING;
                            count[i] <= CW'(1);
                        end
                    end
                    PENDING: begin
                        if (!differs[i]) begin
                            // Bounce back: restart qualification from scratch.
                            state[i] <= IDLE;
                            count[i] <= '0;
                        end else if (update[i]) begin
                            stable[i] <= sync_bit[i];
                            state[i]  <= IDLE;
                            count[i]  <= '0;
                        end else begin
                            count[i] <= count[i] + CW'(1);
                        end
                    end
                    default: begin
                        state[i] <= IDLE;
                        count[i] <= '0;
                    end
                endcase
            end
            busyWire <= |pend_next;
`ifdef DEBOUNCE_CHANGE_PULSE_EN
            changeWire <= |update;
`endif
        end
    end

    assign aWire = stable[3];
    assign bWire = stable[2];
    assign cWire = stable[1];
    assign dWire = stable[0];

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Directed bench for input_debouncer with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// The nominal latency is 6 edges, where edge 1 is the first edge that samples
// the new raw value. Inputs change 1 ns after a rising edge. Outputs are
// checked 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] raw = 4'h0;
    logic       a, b, c, d, busy;
`ifdef DEBOUNCE_CHANGE_PULSE_EN
    logic       change;
`endif
    logic [3:0] outs;

    int n_tests = 0;
    int n_fail  = 0;

    assign outs = {a, b, c, d};

    always #5 clk = ~clk;

    input_debouncer #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .clkWire (clk),
        .rstWire (rst),
        .rawWire (raw),
        .aWire   (a),
        .bWire   (b),
        .cWire   (c),
        .dWire   (d),
        .busyWire(busy)
`ifdef DEBOUNCE_CHANGE_PULSE_EN
        ,
        .changeWire(change)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles with raw low, then release.
    task automatic do_reset();
        rst = 1'b1;
        raw = 4'h0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        raw = 4'hF;
        for (int e = 1; e <= 3; e++) begin
            step();
            n_tests++;
            if (outs !== 4'h0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: outs=%b busy=%b, expected outs=0000 busy=0", e, outs, busy);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            n_tests++;
            if (outs !== ((e >= 6) ? 4'hF : 4'h0)) begin
                n_fail++;
                $display("FAIL reset_release edge %0d: outs=%b expected %b", e, outs, (e >= 6) ? 4'hF : 4'h0);
            end
            n_tests++;
            if (busy !== (e >= 3 && e <= 5)) begin
                n_fail++;
                $display("FAIL reset_release_busy edge %0d: busy=%b expected %b", e, busy, (e >= 3 && e <= 5));
            end
`ifdef DEBOUNCE_CHANGE_PULSE_EN
            n_tests++;
            if (change !== (e == 6)) begin
                n_fail++;
                $display("FAIL reset_release_change edge %0d: change=%b expected %b", e, change, (e == 6));
            end
`endif
        end
    endtask

    task automatic test_clean_edge();
        logic y;
        do_reset();
        raw = 4'b0100;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_tests++;
            if (outs !== ((e >= 6) ? 4'b0100 : 4'b0000)) begin
                n_fail++;
                $display("FAIL clean_edge edge %0d: outs=%b expected %b", e, outs, (e >= 6) ? 4'b0100 : 4'b0000);
            end
            n_tests++;
            if (busy !== (e >= 3 && e <= 5)) begin
                n_fail++;
                $display("FAIL clean_edge_busy edge %0d: busy=%b expected %b", e, busy, (e >= 3 && e <= 5));
            end
`ifdef DEBOUNCE_CHANGE_PULSE_EN
            n_tests++;
            if (change !== (e == 6)) begin
                n_fail++;
                $display("FAIL clean_edge_change edge %0d: change=%b expected %b", e, change, (e == 6));
            end
`endif
        end
        // The downstream function evaluated on the debounced outputs.
        y = (!a && b && !d) || (b && c) || (b && !d);
        n_tests++;
        if (y !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_edge_outwire: y=%b expected 1", y);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            raw[1] = (seg % 2 == 0) ? 1'b1 : 1'b0;
            for (int k = 0; k < 2; k++) begin
                step();
                n_tests++;
                if (c !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce_hold seg %0d: c=%b expected 0", seg, c);
                end
            end
        end
        raw[1] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            n_tests++;
            if (outs !== ((e >= 6) ? 4'b0010 : 4'b0000)) begin
                n_fail++;
                $display("FAIL bounce_settle edge %0d: outs=%b expected %b", e, outs, (e >= 6) ? 4'b0010 : 4'b0000);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        raw[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (e == 3) raw[0] = 1'b0;
            n_tests++;
            if (outs !== 4'h0) begin
                n_fail++;
                $display("FAIL glitch_outs edge %0d: outs=%b expected 0000", e, outs);
            end
            n_tests++;
            if (busy !== (e >= 3 && e <= 5)) begin
                n_fail++;
                $display("FAIL glitch_busy edge %0d: busy=%b expected %b", e, busy, (e >= 3 && e <= 5));
            end
`ifdef DEBOUNCE_CHANGE_PULSE_EN
            n_tests++;
            if (change !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_change edge %0d: change=%b expected 0", e, change);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        raw[3] = 1'b1;
        for (int e = 1; e <= 3; e++) step();
        n_tests++;
        if (busy !== 1'b1 || a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pre: busy=%b a=%b expected busy=1 a=0", busy, a);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: busy=%b a=%b expected busy=0 a=0", busy, a);
        end
        for (int e = 1; e <= 7; e++) begin
            step();
            n_tests++;
            if (a !== (e >= 6)) begin
                n_fail++;
                $display("FAIL reset_mid_requal edge %0d: a=%b expected %b", e, a, (e >= 6));
            end
            n_tests++;
            if (busy !== (e >= 3 && e <= 5)) begin
                n_fail++;
                $display("FAIL reset_mid_busy edge %0d: busy=%b expected %b", e, busy, (e >= 3 && e <= 5));
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        raw = 4'b1111;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_tests++;
            if (outs !== ((e >= 6) ? 4'hF : 4'h0)) begin
                n_fail++;
                $display("FAIL simultaneous edge %0d: outs=%b expected %b", e, outs, (e >= 6) ? 4'hF : 4'h0);
            end
`ifdef DEBOUNCE_CHANGE_PULSE_EN
            n_tests++;
            if (change !== (e == 6)) begin
                n_fail++;
                $display("FAIL simultaneous_change edge %0d: change=%b expected %b", e, change, (e == 6));
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_clean_edge();
        test_bounce();
        test_glitch();
        test_reset_mid();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Upstream conditioning stage for the minimized-logic circuit y = a'bd' + bc + bd'.
- Takes four raw board switch/button signals, synchronizes them to clkWire, and debounces each bit independently.
- Drives clean, glitch-free aWire/bWire/cWire/dWire into the combinational stage, so outWire only changes after a switch has settled.

Parameters:
- DEBOUNCE_CYCLES, 1000000, clock cycles a synchronized input must differ continuously from its output before the output takes the new value (10 ms at 100 MHz); legal range >= 1.
- SYNC_STAGES, 2, flip-flop stages in the per-bit synchronizer; legal range >= 2.

Ports:
- clkWire  input  1  system clock; all logic on its rising edge.
- rstWire  input  1  synchronous, active-high reset.
- rawWire  input  4  asynchronous raw inputs; [3]=a, [2]=b, [1]=c, [0]=d.
- aWire  output  1  debounced a.
- bWire  output  1  debounced b.
- cWire  output  1  debounced c.
- dWire  output  1  debounced d.
- busyWire  output  1  high while any bit's debounce counter is running.

Behaviour:
- Reset: one clock and one reset only. Reset is synchronous and active-high; it takes effect on the rising edge of clkWire where rstWire=1.
  - Synchronizer flops, stable registers and counters all clear to 0.
  - aWire..dWire=0 and busyWire=0 from the first reset edge until the first input update after release.
- Synchronizer: per bit, a chain of SYNC_STAGES flops; its last stage is syncBit.
- Per-bit state machine, counter width = clog2(DEBOUNCE_CYCLES+1):
  - IDLE (syncBit == stable, counter=0): if syncBit != stable, go to PENDING with counter=1. When DEBOUNCE_CYCLES=1, stable updates on this same edge and the bit stays in IDLE.
  - PENDING: if syncBit == stable (bounce back), return to IDLE and clear the counter. If counter == DEBOUNCE_CYCLES-1 and syncBit still differs, set stable <= syncBit, clear the counter and go to IDLE. Otherwise increment the counter.
- Latency: raw held steady after a change → output updates on rising edge number SYNC_STAGES + DEBOUNCE_CYCLES, counting the first edge that samples the new raw value as edge 1.
- Any bounce restarts the full count; partial counts are never carried over.
- Glitch rejection: pulses shorter than DEBOUNCE_CYCLES synchronized cycles never reach the outputs.
- Bits are fully independent. Simultaneous changes on several bits with identical timing update on the same edge.
- busyWire = OR of all bits' PENDING state, registered; it falls on the same edge the final output update happens.
- Reset mid-count: the counter is discarded and the outputs return to 0. After release, a held raw value is re-qualified from scratch, with the full latency counted from the first post-reset sampling edge.
- Outputs are registered only; nothing combinational passes from rawWire to any output.

Optional Feature:
- Macro: DEBOUNCE_CHANGE_PULSE_EN.
- Defined:
  - Adds output port changeWire (1 bit), reset value 0.
  - changeWire is high for exactly one cycle, starting on the edge where any of aWire..dWire updates.
  - One pulse only when several bits update on the same edge.
  - Back-to-back updates on consecutive edges give consecutive pulse cycles.
- Undefined: changeWire port and its logic are absent; all other behaviour is identical.

Test Plan:
- All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, so nominal latency = 6 edges.
- Reset: rawWire=4'hF during 3 reset cycles → aWire..dWire=0 and busyWire=0 while in reset. After release with rawWire held at 4'hF, all four outputs rise together 6 edges later.
- Clean edge: rawWire 4'b0000→4'b0100 and held → bWire rises on edge 6 and busyWire is high edges 3–5. The downstream outWire becomes 1 (a=0, b=1, d=0); changeWire pulses once when the macro is defined.
- Bounce: rawWire[1] toggles every 2 cycles for 12 cycles, then holds at 1 → cWire stays 0 throughout the bounce and rises 6 edges after the final transition.
- Glitch: rawWire[0] high for 3 cycles, then back to 0 → dWire never changes, busyWire pulses, no changeWire.
- Reset mid-count: rawWire[3] goes to 1, then rstWire is asserted on edge 4 for 1 cycle → aWire stays 0 and busyWire clears. aWire rises 6 edges after the first post-reset edge with rawWire[3] still 1.
- Simultaneous: rawWire 4'b0000→4'b1111 in one cycle → all four outputs rise on the same edge 6, with a single one-cycle changeWire pulse.
